// File: rtl/riscv_dmem_responder_if.sv
// Core data-memory port bundle (mem_d_*): the core drives requests as master,
// and the memory responder services them as slave.
interface riscv_dmem_responder_if;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_wr_i;
  logic        mem_rd_i;
  logic [3:0]  mem_wr_i;
  logic        mem_cacheable_i;
  logic [10:0] mem_req_tag_i;
  logic        mem_invalidate_i;
  logic        mem_writeback_i;
  logic        mem_flush_i;
  logic        mem_accept_o;
  logic        mem_ack_o;
  logic        mem_error_o;
  logic [10:0] mem_resp_tag_o;
  logic [31:0] mem_data_rd_o;

  modport master (
    output mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i,
           mem_req_tag_i, mem_invalidate_i, mem_writeback_i, mem_flush_i,
    input  mem_accept_o, mem_ack_o, mem_error_o, mem_resp_tag_o, mem_data_rd_o
  );

  modport slave (
    input  mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i,
           mem_req_tag_i, mem_invalidate_i, mem_writeback_i, mem_flush_i,
    output mem_accept_o, mem_ack_o, mem_error_o, mem_resp_tag_o, mem_data_rd_o
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Data-side memory responder: word RAM with byte-strobed writes, fixed-latency
// in-order tagged responses through a small countdown queue.
module riscv_dmem_responder #(
  parameter logic [31:0] ADDR_BASE       = 32'h80000000,
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  riscv_dmem_responder_if.slave mem
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int QW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CD_INIT  = CW'(LATENCY - 1);
  localparam logic [31:0]   SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [QW:0]   Q_FULL   = (QW + 1)'(MAX_OUTSTANDING);

  logic [31:0]   ram [DEPTH_WORDS];

  logic [10:0]   q_tag  [MAX_OUTSTANDING];
  logic [31:0]   q_data [MAX_OUTSTANDING];
  logic          q_err  [MAX_OUTSTANDING];
  logic [CW-1:0] q_cd   [MAX_OUTSTANDING];

  logic [QW:0]   count_q;
  logic [QW-1:0] wr_ptr_q;
  logic [QW-1:0] rd_ptr_q;

  logic          wr_any;
  logic          present;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          req_err;
  logic          ram_wr;
  logic [31:0]   req_data;
  logic          unused_bits;

  // Request decode and classification; accept comes from the registered count only.
  always_comb begin
    wr_any   = |mem.mem_wr_i;
    present  = mem.mem_rd_i | wr_any | mem.mem_invalidate_i |
               mem.mem_writeback_i | mem.mem_flush_i;
    accept   = (count_q < Q_FULL);
    push     = present & accept;
    offset   = mem.mem_addr_i - ADDR_BASE;
    in_range = (offset < SPAN);
    word_idx = offset[AW+1:2];
    req_err  = (mem.mem_rd_i & wr_any) | ((mem.mem_rd_i | wr_any) & ~in_range);
    ram_wr   = push & wr_any & ~req_err;
    req_data = (mem.mem_rd_i && !req_err) ? ram[word_idx] : 32'h0;
    pop      = (count_q != '0) && (q_cd[rd_ptr_q] == '0);
  end

  assign mem.mem_accept_o = accept;
  assign unused_bits = ^{mem.mem_cacheable_i, offset[31:AW+2], offset[1:0]};

  always_ff @(posedge clk_i) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (mem.mem_wr_i[b]) ram[word_idx][8*b +: 8] <= mem.mem_data_wr_i[8*b +: 8];
      end
    end
  end

  // Queue payload: every countdown ages each cycle; the pushed slot is reloaded.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (q_cd[i] != '0) q_cd[i] <= q_cd[i] - 1'b1;
    end
    if (push) begin
      q_tag[wr_ptr_q]  <= mem.mem_req_tag_i;
      q_data[wr_ptr_q] <= req_data;
      q_err[wr_ptr_q]  <= req_err;
      q_cd[wr_ptr_q]   <= CD_INIT;
    end
  end

  // Queue control and registered response; reset drops anything pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q            <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      mem.mem_ack_o      <= 1'b0;
      mem.mem_error_o    <= 1'b0;
      mem.mem_resp_tag_o <= '0;
      mem.mem_data_rd_o  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_q + (QW + 1)'(push) - (QW + 1)'(pop);
      mem.mem_ack_o <= pop;
      if (pop) begin
        mem.mem_resp_tag_o <= q_tag[rd_ptr_q];
        mem.mem_data_rd_o  <= q_data[rd_ptr_q];
        mem.mem_error_o    <= q_err[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench: one responder at LATENCY=2 for data/decode paths, one at
// LATENCY=4 to fill the queue and exercise back-pressure.
module tb_riscv_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_dmem_responder_if ifa ();
  riscv_dmem_responder_if ifb ();

  riscv_dmem_responder #(.LATENCY(2)) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .mem   (ifa)
  );

  riscv_dmem_responder #(.LATENCY(4), .MAX_OUTSTANDING(4)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .mem   (ifb)
  );

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic idle_a();
    ifa.mem_rd_i = 1'b0; ifa.mem_wr_i = 4'h0; ifa.mem_addr_i = 32'h0;
    ifa.mem_data_wr_i = 32'h0; ifa.mem_req_tag_i = 11'h0; ifa.mem_cacheable_i = 1'b0;
    ifa.mem_invalidate_i = 1'b0; ifa.mem_writeback_i = 1'b0; ifa.mem_flush_i = 1'b0;
  endtask

  task automatic idle_b();
    ifb.mem_rd_i = 1'b0; ifb.mem_wr_i = 4'h0; ifb.mem_addr_i = 32'h0;
    ifb.mem_data_wr_i = 32'h0; ifb.mem_req_tag_i = 11'h0; ifb.mem_cacheable_i = 1'b0;
    ifb.mem_invalidate_i = 1'b0; ifb.mem_writeback_i = 1'b0; ifb.mem_flush_i = 1'b0;
  endtask

  task automatic drive_a(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [10:0] tag, input logic fl);
    ifa.mem_rd_i = rd; ifa.mem_wr_i = wr; ifa.mem_addr_i = addr;
    ifa.mem_data_wr_i = wdata; ifa.mem_req_tag_i = tag; ifa.mem_flush_i = fl;
  endtask

  task automatic issue_a(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [10:0] tag, input logic fl);
    drive_a(rd, wr, addr, wdata, tag, fl);
    @(posedge clk); #1;
    idle_a();
  endtask

  task automatic wait_ack_a(input string name, input logic [10:0] tag,
                            input logic [31:0] data, input logic err);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.mem_ack_o && n < 12);
    chk({name, "_ack"},  ifa.mem_ack_o, 32'd1);
    chk({name, "_tag"},  ifa.mem_resp_tag_o, tag);
    chk({name, "_data"}, ifa.mem_data_rd_o, data);
    chk({name, "_err"},  ifa.mem_error_o, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc_hist [16];
    logic [10:0] ack_tag [6];
    int          ack_cyc [6];
    int          exp_cyc [6];
    int          nack;
    int          next_tag;
    int          stray;

    idle_a();
    idle_b();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ack",    ifa.mem_ack_o, 32'd0);
    chk("rst_err",    ifa.mem_error_o, 32'd0);
    chk("rst_tag",    ifa.mem_resp_tag_o, 32'd0);
    chk("rst_data",   ifa.mem_data_rd_o, 32'd0);
    chk("rst_acc_a",  ifa.mem_accept_o, 32'd1);
    chk("rst_acc_b",  ifb.mem_accept_o, 32'd1);

    // 1: write then read-after-write, exact latency
    @(posedge clk); #1;
    drive_a(1'b0, 4'hF, 32'h80000004, 32'hA5A5A5A5, 11'h011, 1'b0);
    @(posedge clk); #1;
    drive_a(1'b1, 4'h0, 32'h80000004, 32'h0, 11'h012, 1'b0);
    @(posedge clk); #1;
    idle_a();
    @(negedge clk);
    chk("t1_no_early_ack", ifa.mem_ack_o, 32'd0);
    @(negedge clk);
    chk("t1_wr_ack",  ifa.mem_ack_o, 32'd1);
    chk("t1_wr_tag",  ifa.mem_resp_tag_o, 32'h011);
    chk("t1_wr_err",  ifa.mem_error_o, 32'd0);
    chk("t1_wr_data", ifa.mem_data_rd_o, 32'd0);
    @(negedge clk);
    chk("t1_rd_ack",  ifa.mem_ack_o, 32'd1);
    chk("t1_rd_tag",  ifa.mem_resp_tag_o, 32'h012);
    chk("t1_rd_data", ifa.mem_data_rd_o, 32'hA5A5A5A5);
    chk("t1_rd_err",  ifa.mem_error_o, 32'd0);
    @(negedge clk);
    chk("t1_ack_drop",  ifa.mem_ack_o, 32'd0);
    chk("t1_tag_hold",  ifa.mem_resp_tag_o, 32'h012);
    chk("t1_data_hold", ifa.mem_data_rd_o, 32'hA5A5A5A5);

    // 2: single-byte strobe merge
    issue_a(1'b0, 4'b0010, 32'h80000004, 32'h0000FF00, 11'h021, 1'b0);
    issue_a(1'b1, 4'h0,    32'h80000004, 32'h0,        11'h022, 1'b0);
    wait_ack_a("t2_wr", 11'h021, 32'h0, 1'b0);
    wait_ack_a("t2_rd", 11'h022, 32'hA5A5FFA5, 1'b0);

    // 3: out-of-range and range boundaries
    issue_a(1'b0, 4'hF, 32'h80000000, 32'hCAFEF00D, 11'h050, 1'b0);
    wait_ack_a("t3_seed", 11'h050, 32'h0, 1'b0);
    issue_a(1'b1, 4'h0, 32'h70000000, 32'h0, 11'h055, 1'b0);
    wait_ack_a("t3_oor_rd", 11'h055, 32'h0, 1'b1);
    issue_a(1'b0, 4'hF, 32'h70000000, 32'h12345678, 11'h056, 1'b0);
    wait_ack_a("t3_oor_wr", 11'h056, 32'h0, 1'b1);
    issue_a(1'b1, 4'h0, 32'h80000000, 32'h0, 11'h057, 1'b0);
    wait_ack_a("t3_base_rb", 11'h057, 32'hCAFEF00D, 1'b0);
    issue_a(1'b0, 4'hF, 32'h80000FFF, 32'h0BADBEEF, 11'h05A, 1'b0);
    wait_ack_a("t3_top_wr", 11'h05A, 32'h0, 1'b0);
    issue_a(1'b1, 4'h0, 32'h80000FFC, 32'h0, 11'h05B, 1'b0);
    wait_ack_a("t3_top_rd", 11'h05B, 32'h0BADBEEF, 1'b0);
    issue_a(1'b1, 4'h0, 32'h80001000, 32'h0, 11'h058, 1'b0);
    wait_ack_a("t3_past_end", 11'h058, 32'h0, 1'b1);

    // 4: fill the LATENCY=4 queue with six continuous reads
    @(posedge clk); #1;
    nack = 0;
    next_tag = 1;
    ifb.mem_rd_i = 1'b1;
    ifb.mem_addr_i = 32'h80000000;
    ifb.mem_req_tag_i = 11'(next_tag);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      acc_hist[c] = ifb.mem_accept_o;
      if (ifb.mem_ack_o) begin
        if (nack < 6) begin
          ack_tag[nack] = ifb.mem_resp_tag_o;
          ack_cyc[nack] = c;
        end
        nack++;
      end
      @(posedge clk);
      if (ifb.mem_rd_i && acc_hist[c]) next_tag++;
      #1;
      ifb.mem_rd_i = (next_tag <= 6);
      ifb.mem_req_tag_i = 11'(next_tag);
    end
    idle_b();
    chk("t4_acc_open",   acc_hist[3], 32'd1);
    chk("t4_acc_full",   acc_hist[4], 32'd0);
    chk("t4_acc_reopen", acc_hist[5], 32'd1);
    chk("t4_nack",       nack, 32'd6);
    exp_cyc = '{5, 6, 7, 8, 10, 11};
    for (int i = 0; i < 6; i++) begin
      if (i < nack) begin
        chk($sformatf("t4_tag%0d", i + 1), ack_tag[i], 32'(i + 1));
        chk($sformatf("t4_cyc%0d", i + 1), ack_cyc[i], exp_cyc[i]);
      end
    end

    // 5: read+write conflict, then maintenance-only op
    issue_a(1'b0, 4'hF, 32'h80000008, 32'h11223344, 11'h060, 1'b0);
    wait_ack_a("t5_seed", 11'h060, 32'h0, 1'b0);
    issue_a(1'b1, 4'hF, 32'h80000008, 32'hFFFFFFFF, 11'h061, 1'b0);
    wait_ack_a("t5_rdwr", 11'h061, 32'h0, 1'b1);
    issue_a(1'b1, 4'h0, 32'h80000008, 32'h0, 11'h062, 1'b0);
    wait_ack_a("t5_rb", 11'h062, 32'h11223344, 1'b0);
    issue_a(1'b0, 4'h0, 32'h80000008, 32'h0, 11'h7FF, 1'b1);
    wait_ack_a("t5_flush", 11'h7FF, 32'h0, 1'b0);

    // 6: asynchronous reset with responses pending
    @(posedge clk); #1;
    ifb.mem_rd_i = 1'b1;
    ifb.mem_addr_i = 32'h80000000;
    ifb.mem_req_tag_i = 11'h100;
    @(posedge clk); #1;
    drive_a(1'b1, 4'h0, 32'h80000004, 32'h0, 11'h071, 1'b0);
    @(posedge clk); #1;
    drive_a(1'b1, 4'h0, 32'h80000004, 32'h0, 11'h072, 1'b0);
    @(posedge clk); #1;
    drive_a(1'b1, 4'h0, 32'h80000004, 32'h0, 11'h073, 1'b0);
    @(posedge clk); #1;
    idle_a();
    idle_b();
    chk("t6_pre_ack",   ifa.mem_ack_o, 32'd1);
    chk("t6_pre_tag",   ifa.mem_resp_tag_o, 32'h071);
    chk("t6_pre_acc_b", ifb.mem_accept_o, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ack",   ifa.mem_ack_o, 32'd0);
    chk("t6_rst_tag",   ifa.mem_resp_tag_o, 32'd0);
    chk("t6_rst_data",  ifa.mem_data_rd_o, 32'd0);
    chk("t6_rst_err",   ifa.mem_error_o, 32'd0);
    chk("t6_rst_acc_a", ifa.mem_accept_o, 32'd1);
    chk("t6_rst_acc_b", ifb.mem_accept_o, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifa.mem_ack_o || ifb.mem_ack_o) stray++;
    end
    chk("t6_no_acks", stray, 32'd0);
    @(posedge clk); #1;
    issue_a(1'b1, 4'h0, 32'h80000004, 32'h0, 11'h074, 1'b0);
    wait_ack_a("t6_ram_kept", 11'h074, 32'hA5A5FFA5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
